// File: rtl/regs_banked.sv
// Banked register file with a masked flag register (R0) per bank and a
// handshake-driven engine that saves (spills) or loads (fills) one whole bank.
module regs_banked #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int NBANKS = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic             clk_sys,
  input  logic             clr_,
  input  logic [BW-1:0]    bank_sel,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] w,
  input  logic [AW-1:0]    ra_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] la,
  output logic [WIDTH-1:0] lb,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] flag_mask,
  input  logic [WIDTH-1:0] flag_val,
  output logic [WIDTH-1:0] r0,
  input  logic             spill_start,
  input  logic             fill_start,
  input  logic [BW-1:0]    xfer_bank,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_idx,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [BW-1:0]    xbank;
  logic [WIDTH-1:0] regs     [NBANKS][NREGS];
  logic [WIDTH-1:0] regs_nxt [NBANKS][NREGS];
  logic             locked;
  logic             wr_ok;
  logic             flag_ok;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_req   = (state == SPILL) || (state == FILL);
  assign mem_we    = (state == SPILL);
  assign mem_idx   = idx;
  assign mem_wdata = (state == SPILL) ? regs[xbank][idx] : '0;
  assign r0        = regs[bank_sel][0];

  // The bank under transfer is owned by the engine; CPU updates to it are dropped.
  assign locked  = busy && (bank_sel == xbank);
  assign wr_ok   = we && !locked;
  assign flag_ok = flag_we && !locked;

  // Next-state image of the array; read ports sample it so they see same-edge writes.
  always_comb begin
    regs_nxt = regs;
    if (flag_ok)
      regs_nxt[bank_sel][0] = (regs[bank_sel][0] & ~flag_mask) | (flag_val & flag_mask);
    if (wr_ok)
      regs_nxt[bank_sel][wa] = w;
    if ((state == FILL) && mem_ack)
      regs_nxt[xbank][idx] = mem_rdata;
  end

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      for (int b = 0; b < NBANKS; b++)
        for (int r = 0; r < NREGS; r++)
          regs[b][r] <= '0;
      la    <= '0;
      lb    <= '0;
      err   <= 1'b0;
      idx   <= '0;
      xbank <= '0;
      state <= IDLE;
    end else begin
      regs <= regs_nxt;
      la   <= regs_nxt[bank_sel][ra_a];
      lb   <= regs_nxt[bank_sel][ra_b];
      err  <= busy && (spill_start || fill_start);
      case (state)
        IDLE: begin
          if (spill_start || fill_start) begin
            xbank <= xfer_bank;
            idx   <= '0;
            state <= spill_start ? SPILL : FILL;
          end
        end
        SPILL, FILL: begin
          if (mem_ack) begin
            if (idx == AW'(NREGS - 1))
              state <= DONE;
            else
              idx <= idx + AW'(1);
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_banked.sv
// Directed bench for regs_banked: CPU ports, flag masking, bypass, spill/fill
// handshakes, busy-time rejections and asynchronous reset abort.
module tb_regs_banked;

  logic        clk_sys = 1'b0;
  logic        clr_ = 1'b0;
  logic [0:0]  bank_sel = '0;
  logic        we = 1'b0;
  logic [2:0]  wa = '0;
  logic [15:0] w = '0;
  logic [2:0]  ra_a = '0;
  logic [2:0]  ra_b = '0;
  logic [15:0] la, lb;
  logic        flag_we = 1'b0;
  logic [15:0] flag_mask = '0;
  logic [15:0] flag_val = '0;
  logic [15:0] r0;
  logic        spill_start = 1'b0;
  logic        fill_start = 1'b0;
  logic [0:0]  xfer_bank = '0;
  logic        mem_req, mem_we;
  logic [2:0]  mem_idx;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  regs_banked #(.WIDTH(16), .NREGS(8), .NBANKS(2)) dut (
    .clk_sys(clk_sys), .clr_(clr_), .bank_sel(bank_sel),
    .we(we), .wa(wa), .w(w), .ra_a(ra_a), .ra_b(ra_b), .la(la), .lb(lb),
    .flag_we(flag_we), .flag_mask(flag_mask), .flag_val(flag_val), .r0(r0),
    .spill_start(spill_start), .fill_start(fill_start), .xfer_bank(xfer_bank),
    .mem_req(mem_req), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_la", la, 0);
    chk("rst_lb", lb, 0);
    chk("rst_r0", r0, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_idx", mem_idx, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    tick();
    clr_ = 1'b1;
    tick();

    // basic write then banked read
    bank_sel = 1; we = 1; wa = 3; w = 16'h1234;
    tick();
    we = 0; ra_a = 3;
    tick();
    chk("read_b1_r3", la, 16'h1234);
    bank_sel = 0;
    tick();
    chk("read_b0_r3", la, 16'h0000);

    // bypass on write
    bank_sel = 1; we = 1; wa = 5; w = 16'h5555; ra_b = 5;
    tick();
    we = 0;
    chk("bypass_wr_lb", lb, 16'h5555);

    // flag update, flag bypass, write-over-flag priority
    bank_sel = 0; we = 1; wa = 0; w = 16'hFF00;
    tick();
    we = 0; flag_we = 1; flag_mask = 16'h0F0F; flag_val = 16'h0505; ra_a = 0;
    tick();
    chk("flag_r0", r0, 16'hF505);
    chk("flag_bypass_la", la, 16'hF505);
    we = 1; wa = 0; w = 16'hAAAA;
    tick();
    we = 0; flag_we = 0;
    chk("wr_beats_flag", r0, 16'hAAAA);

    // spill bank 0 with ack always high
    for (int i = 0; i < 8; i++) begin
      bank_sel = 0; we = 1; wa = 3'(i); w = 16'h0100 + 16'(i);
      tick();
    end
    we = 0;
    spill_start = 1; xfer_bank = 0; mem_ack = 1;
    tick();
    spill_start = 0;
    chk("spill_busy", busy, 1);
    chk("spill_we", mem_we, 1);
    for (int i = 0; i < 8; i++) begin
      chk("spill_req", mem_req, 1);
      chk("spill_idx", mem_idx, 32'(i));
      chk("spill_wdata", mem_wdata, 32'h0100 + 32'(i));
      tick();
    end
    chk("spill_done", done, 1);
    chk("spill_done_req", mem_req, 0);
    mem_ack = 0;
    tick();
    chk("spill_done_pulse", done, 0);
    chk("spill_idle_busy", busy, 0);

    // fill bank 1, ack every third cycle, CPU writes and rejected start
    fill_start = 1; xfer_bank = 1; mem_ack = 0;
    tick();
    fill_start = 0;
    chk("fill_we", mem_we, 0);
    chk("fill_req", mem_req, 1);
    bank_sel = 1; we = 1; wa = 2; w = 16'hDEAD;
    tick();
    bank_sel = 0; we = 1; wa = 2; w = 16'h2222;
    tick();
    we = 0; spill_start = 1;
    tick();
    spill_start = 0;
    chk("busy_err", err, 1);
    chk("busy_err_we", mem_we, 0);
    chk("busy_err_idx", mem_idx, 0);
    tick();
    chk("busy_err_pulse", err, 0);
    chk("fill_still_req", mem_req, 1);
    for (int k = 0; k < 8; k++) begin
      chk("fill_idx", mem_idx, 32'(k));
      mem_rdata = 16'hBEE0 + 16'(k);
      mem_ack = 0;
      tick();
      tick();
      mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    chk("fill_done", done, 1);
    tick();
    chk("fill_idle_busy", busy, 0);
    bank_sel = 1;
    for (int i = 0; i < 8; i++) begin
      ra_a = 3'(i);
      tick();
      chk("fill_data", la, 32'hBEE0 + 32'(i));
    end
    bank_sel = 0; ra_a = 2; ra_b = 3;
    tick();
    chk("other_bank_wr", la, 16'h2222);
    chk("other_bank_keep", lb, 16'h0103);

    // simultaneous starts pick spill; spill bank 1 with ack high
    spill_start = 1; fill_start = 1; xfer_bank = 1; mem_ack = 1;
    tick();
    spill_start = 0; fill_start = 0;
    chk("both_start_we", mem_we, 1);
    for (int i = 0; i < 8; i++) begin
      chk("spill_b1_wdata", mem_wdata, 32'hBEE0 + 32'(i));
      tick();
    end
    mem_ack = 0;
    chk("spill_b1_done", done, 1);
    tick();

    // reset mid-spill aborts
    spill_start = 1; xfer_bank = 0; mem_ack = 1;
    tick();
    spill_start = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_idx4", mem_idx, 4);
    clr_ = 0;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", mem_idx, 0);
    chk("abort_wdata", mem_wdata, 0);
    chk("abort_la", la, 0);
    mem_ack = 0;
    #1;
    clr_ = 1;
    tick();
    chk("abort_no_done", done, 0);
    chk("abort_idle", busy, 0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        bank_sel = 1'(b); ra_a = 3'(i);
        tick();
        chk("abort_cleared", la, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
